// File: rtl/clock_divider_bank.sv
// Bank of independent runtime-programmable clock dividers.
// Each channel emits a 50% duty toggle and a one-cycle tick strobe.
module clock_divider_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = 25_000_000,
  parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              div_we,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Select is zero-extended so out-of-range addresses match no channel.
  logic [31:0] w_sel;
  assign w_sel = 32'(div_sel);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic             r_clk;
    logic             r_tick;
    logic [CNT_W-1:0] w_eff;
    logic             w_hit;
    logic             w_term;

    // A zero divisor behaves like one: tick every enabled cycle.
    assign w_eff  = (r_div == '0) ? ONE : r_div;
    assign w_term = (r_cnt == (w_eff - ONE));
    assign w_hit  = div_we && (w_sel == 32'(i));

    // Counter, divisor and outputs; clear beats write beats count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt  <= '0;
        r_div  <= DEF_DIV;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (sync_clr) begin
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (w_hit) begin
        r_div  <= div_data;
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (!en[i]) begin
        r_tick <= 1'b0;
      end else if (w_term) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
        r_clk  <= ~r_clk;
      end else begin
        r_cnt  <= r_cnt + ONE;
        r_tick <= 1'b0;
      end
    end

    assign clk_out[i] = r_clk;
    assign tick[i]    = r_tick;
  end

endmodule
